// File: rtl/compare_sink_if.sv
// compare_sink_if: sample and failure-report bus for compare_sink.
//   in_*     : stimulus/response sample stream (valid/ready)
//   rpt_*    : failure-record readout stream (valid/ready)
// master = driver/consumer side, slave = compare_sink.
interface compare_sink_if #(
  parameter int NOUT = 5,
  parameter int W    = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [15:0]            in_tag;
  logic [NOUT*W*2-1:0]    spec_v;
  logic [NOUT*W*2-1:0]    impl_v;
  logic                   rpt_valid;
  logic                   rpt_ready;
  logic [15:0]            rpt_tag;
  logic [NOUT-1:0]        rpt_mask;
  logic [NOUT*W*2-1:0]    rpt_spec;
  logic [NOUT*W*2-1:0]    rpt_impl;

  modport master (
    output in_valid, in_tag, spec_v, impl_v, rpt_ready,
    input  in_ready, rpt_valid, rpt_tag, rpt_mask, rpt_spec, rpt_impl
  );

  modport slave (
    input  in_valid, in_tag, spec_v, impl_v, rpt_ready,
    output in_ready, rpt_valid, rpt_tag, rpt_mask, rpt_spec, rpt_impl
  );
endinterface

// File: rtl/compare_sink.sv
// compare_sink: hardware response checker. Accepts {tag, spec, impl} samples,
// compares each output slice with case-equality on 2-bit four-state codes
// (00=0 01=1 10=X 11=Z), counts samples/failures (saturating) and queues
// failing records in a small FIFO for readout.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start, clear     IDLE->RUN pulse; clear returns to IDLE and wipes state
//   bus (slave)      sample input stream and failure-record output stream
//   sample_cnt       accepted samples
//   fail_cnt         failing samples
//   overflow         sticky: a failing record was dropped (FIFO full)
//   halted           block stopped after a failure (STOP_ON_FAIL)
//   all_ok           no failures seen

// Per-output compare: raw code compare gives === semantics (X != Z, X != 0).
module compare_sink_lane #(
  parameter int W = 8
) (
  input  logic [2*W-1:0] spec,
  input  logic [2*W-1:0] impl,
  output logic           mismatch
);
  assign mismatch = (spec != impl);
endmodule

module compare_sink #(
  parameter int NOUT         = 5,
  parameter int W            = 8,
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clear,
  compare_sink_if.slave       bus,
  output logic [CNT_W-1:0]    sample_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic                overflow,
  output logic                halted,
  output logic                all_ok
);
  localparam int VW = NOUT*W*2;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  typedef struct packed {
    logic [15:0]     tag;
    logic [NOUT-1:0] mask;
    logic [VW-1:0]   spec;
    logic [VW-1:0]   impl;
  } rec_t;

  state_t          state, state_nxt;
  logic [NOUT-1:0] mismatch;
  logic            accept, fail_acc, push, pop, full;
  rec_t            mem [DEPTH];
  rec_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  for (genvar k = 0; k < NOUT; k++) begin : g_lane
    compare_sink_lane #(.W(W)) u_lane (
      .spec     (bus.spec_v[k*W*2 +: W*2]),
      .impl     (bus.impl_v[k*W*2 +: W*2]),
      .mismatch (mismatch[k])
    );
  end

  assign accept   = bus.in_valid & bus.in_ready;
  assign fail_acc = accept & (|mismatch);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop      = bus.rpt_valid & bus.rpt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push     = fail_acc & (~full | pop);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state; clear overrides everything
  always_comb begin
    state_nxt = state;
    if (clear) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (fail_acc && STOP_ON_FAIL) state_nxt = HALT;
        HALT:    state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs depend on the state register only
  always_comb begin
    bus.in_ready = (state == RUN);
    halted       = (state == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      fail_cnt   <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      sample_cnt <= '0;
      fail_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept && sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
      if (fail_acc && fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
      if (fail_acc && !push)          overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{tag: bus.in_tag, mask: mismatch,
                         spec: bus.spec_v, impl: bus.impl_v};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.rpt_valid = (count != '0);
  assign bus.rpt_tag   = head.tag;
  assign bus.rpt_mask  = head.mask;
  assign bus.rpt_spec  = head.spec;
  assign bus.rpt_impl  = head.impl;
  assign all_ok        = (fail_cnt == '0);
endmodule

// File: tb/tb_compare_sink.sv
// Bench for compare_sink: two instances share one stimulus stream
// (a: STOP_ON_FAIL=0, CNT_W=4; b: STOP_ON_FAIL=1, CNT_W=16) and are checked
// every cycle against a queue-based behavioural model.
module tb_compare_sink;
  localparam int NOUT = 5, W = 8, DEPTH = 4, VW = NOUT*W*2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear = 1'b0;
  logic in_valid = 1'b0, rpt_ready = 1'b0;
  logic [15:0] in_tag = '0;
  logic [VW-1:0] spec_v = '0, impl_v = '0;

  compare_sink_if #(.NOUT(NOUT), .W(W)) ifa ();
  compare_sink_if #(.NOUT(NOUT), .W(W)) ifb ();
  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.in_tag   = in_tag;    assign ifb.in_tag   = in_tag;
  assign ifa.spec_v   = spec_v;    assign ifb.spec_v   = spec_v;
  assign ifa.impl_v   = impl_v;    assign ifb.impl_v   = impl_v;
  assign ifa.rpt_ready = rpt_ready; assign ifb.rpt_ready = rpt_ready;

  logic [3:0]  sc_a, fc_a;
  logic [15:0] sc_b, fc_b;
  logic ovf_a, hlt_a, ok_a, ovf_b, hlt_b, ok_b;

  compare_sink #(.NOUT(NOUT), .W(W), .DEPTH(DEPTH), .CNT_W(4), .STOP_ON_FAIL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .bus(ifa),
    .sample_cnt(sc_a), .fail_cnt(fc_a), .overflow(ovf_a), .halted(hlt_a), .all_ok(ok_a));
  compare_sink #(.NOUT(NOUT), .W(W), .DEPTH(DEPTH), .CNT_W(16), .STOP_ON_FAIL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .bus(ifb),
    .sample_cnt(sc_b), .fail_cnt(fc_b), .overflow(ovf_b), .halted(hlt_b), .all_ok(ok_b));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] tag; logic [NOUT-1:0] mask; logic [VW-1:0] spec; logic [VW-1:0] impl;
  } rec_t;
  int   m_st [2];   // 0 idle, 1 run, 2 halt
  int   m_smp[2];
  int   m_fail[2];
  bit   m_ovf[2];
  rec_t mq[2][$];
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  function automatic int cmax(input int i); return (i == 0) ? 15 : 65535; endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_smp[i] = 0; m_fail[i] = 0; m_ovf[i] = 0; mq[i].delete();
    end
  endfunction

  function automatic void model_edge();
    logic [NOUT-1:0] mask;
    for (int k = 0; k < NOUT; k++)
      mask[k] = (spec_v[k*W*2 +: W*2] !== impl_v[k*W*2 +: W*2]);
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        m_st[i] = 0; m_smp[i] = 0; m_fail[i] = 0; m_ovf[i] = 0; mq[i].delete();
      end else begin
        bit acc = in_valid && (m_st[i] == 1);
        if (rpt_ready && mq[i].size() > 0) void'(mq[i].pop_front());
        if (acc) begin
          if (m_smp[i] < cmax(i)) m_smp[i]++;
          if (mask != 0) begin
            if (m_fail[i] < cmax(i)) m_fail[i]++;
            if (mq[i].size() < DEPTH) mq[i].push_back('{in_tag, mask, spec_v, impl_v});
            else m_ovf[i] = 1;
            if (i == 1) m_st[i] = 2;
          end
        end
        if (m_st[i] == 0 && start) m_st[i] = 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_in_ready", ifa.in_ready, m_st[0] == 1);
    chk("a_halted",   hlt_a, m_st[0] == 2);
    chk("a_smp",      sc_a, m_smp[0]);
    chk("a_fail",     fc_a, m_fail[0]);
    chk("a_all_ok",   ok_a, m_fail[0] == 0);
    chk("a_ovf",      ovf_a, m_ovf[0]);
    chk("a_rpt_valid", ifa.rpt_valid, mq[0].size() > 0);
    if (mq[0].size() > 0) begin
      chk("a_rpt_tag",  ifa.rpt_tag,  mq[0][0].tag);
      chk("a_rpt_mask", ifa.rpt_mask, mq[0][0].mask);
      chk("a_rpt_spec", ifa.rpt_spec, mq[0][0].spec);
      chk("a_rpt_impl", ifa.rpt_impl, mq[0][0].impl);
    end
    chk("b_in_ready", ifb.in_ready, m_st[1] == 1);
    chk("b_halted",   hlt_b, m_st[1] == 2);
    chk("b_smp",      sc_b, m_smp[1]);
    chk("b_fail",     fc_b, m_fail[1]);
    chk("b_all_ok",   ok_b, m_fail[1] == 0);
    chk("b_ovf",      ovf_b, m_ovf[1]);
    chk("b_rpt_valid", ifb.rpt_valid, mq[1].size() > 0);
    if (mq[1].size() > 0) begin
      chk("b_rpt_tag",  ifb.rpt_tag,  mq[1][0].tag);
      chk("b_rpt_mask", ifb.rpt_mask, mq[1][0].mask);
      chk("b_rpt_spec", ifb.rpt_spec, mq[1][0].spec);
      chk("b_rpt_impl", ifb.rpt_impl, mq[1][0].impl);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
    check_all();
  endtask

  // Random sample; two_state limits codes to 00/01. A failing sample gets one
  // code changed to a different code in a random position.
  task automatic gen(input int fail_pct, input bit two_state);
    for (int k = 0; k < NOUT*W; k++)
      spec_v[k*2 +: 2] = two_state ? {1'b0, 1'($urandom_range(1))} : 2'($urandom_range(3));
    impl_v = spec_v;
    if (int'($urandom_range(99)) < fail_pct) begin
      int p = $urandom_range(NOUT*W-1);
      impl_v[p*2 +: 2] = spec_v[p*2 +: 2] ^ 2'($urandom_range(1, 3));
    end
    in_tag = 16'($urandom);
  endtask

  task automatic restart();
    in_valid = 0; clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
  endtask

  logic [15:0] tag3;
  logic [15:0] t3tags [6];
  int pops;

  initial begin
    // reset
    #2 model_reset();
    check_all();
    chk("rst_rpt_tag",  ifa.rpt_tag, 16'h0);
    chk("rst_rpt_spec", ifb.rpt_spec, '0);
    #10 rst_n = 1;

    // 10 passing two-state samples
    start = 1; step(); start = 0;
    for (int j = 0; j < 10; j++) begin in_valid = 1; gen(0, 1); step(); end
    in_valid = 0; step();
    chk("t1_smp", sc_b, 16'd10);
    chk("t1_fail", fc_b, 16'd0);
    chk("t1_ok", ok_b, 1'b1);
    chk("t1_rpt_valid", ifb.rpt_valid, 1'b0);

    // X vs Z on output 2 bit 0 as the 3rd sample
    restart();
    rpt_ready = 0;
    for (int j = 0; j < 2; j++) begin in_valid = 1; gen(0, 1); step(); end
    gen(0, 1);
    spec_v[33:32] = 2'b10; impl_v[33:32] = 2'b11; tag3 = in_tag;
    step();
    chk("t2_mask", ifb.rpt_mask, 5'b00100);
    chk("t2_tag", ifb.rpt_tag, tag3);
    chk("t2_halted", hlt_b, 1'b1);
    chk("t2_in_ready", ifb.in_ready, 1'b0);
    chk("t2_smp", sc_b, 16'd3);
    chk("t2_fail", fc_b, 16'd1);
    for (int j = 0; j < 3; j++) begin gen(50, 0); step(); end
    chk("t2_smp_frozen", sc_b, 16'd3);

    // 6 failures, no readout: first 4 kept in order, overflow set
    restart();
    for (int j = 0; j < 6; j++) begin in_valid = 1; gen(100, 0); t3tags[j] = in_tag; step(); end
    in_valid = 0; step();
    chk("t3_ovf", ovf_a, 1'b1);
    chk("t3_fail", fc_a, 4'd6);
    for (int j = 0; j < 4; j++) begin
      chk("t3_order", ifa.rpt_tag, t3tags[j]);
      rpt_ready = 1; step();
    end
    rpt_ready = 0;
    chk("t3_empty", ifa.rpt_valid, 1'b0);

    // full FIFO + pop during a failing accept: nothing lost
    restart();
    for (int j = 0; j < 4; j++) begin in_valid = 1; gen(100, 0); step(); end
    rpt_ready = 1; gen(100, 0); step();
    in_valid = 0; rpt_ready = 0; step();
    chk("t4_ovf", ovf_a, 1'b0);
    pops = 0;
    rpt_ready = 1;
    for (int j = 0; j < 8; j++) if (ifa.rpt_valid) begin pops++; step(); end
    rpt_ready = 0;
    chk("t4_occupancy", pops, 4);

    // saturation at 15 for the 4-bit instance
    restart();
    for (int j = 0; j < 20; j++) begin
      in_valid = 1; rpt_ready = 1'($urandom_range(1)); gen(100, 0); step();
    end
    in_valid = 0; rpt_ready = 0; step();
    chk("t5_smp_sat", sc_a, 4'hF);
    chk("t5_fail_sat", fc_a, 4'hF);

    // clear wins over a same-cycle failing accept
    restart();
    for (int j = 0; j < 6; j++) begin in_valid = 1; gen(100, 0); step(); end
    clear = 1; gen(100, 0); step(); clear = 0; in_valid = 0;
    chk("t6_smp", sc_a, 4'd0);
    chk("t6_ovf", ovf_a, 1'b0);
    chk("t6_rpt_valid", ifa.rpt_valid, 1'b0);
    chk("t6_in_ready", ifa.in_ready, 1'b0);
    step();

    // random traffic
    for (int j = 0; j < 300; j++) begin
      start     = ($urandom_range(9) == 0);
      clear     = ($urandom_range(49) == 0);
      in_valid  = 1'($urandom_range(1));
      rpt_ready = ($urandom_range(3) == 0);
      gen(30, 0);
      step();
    end
    start = 0; clear = 0;

    // asynchronous reset mid-stream
    restart();
    for (int j = 0; j < 5; j++) begin in_valid = 1; gen(60, 0); step(); end
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    chk("t7_smp", sc_a, 4'd0);
    chk("t7_rpt_tag", ifa.rpt_tag, 16'h0);
    #1 rst_n = 1;
    in_valid = 0; start = 1; step(); start = 0;
    for (int j = 0; j < 4; j++) begin in_valid = 1; gen(50, 0); step(); end
    in_valid = 0; step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
